// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: interrupt capture, priority selection and CPU handshake.
//
// Captures raw interrupt lines into a software-visible pending register.
// Capture is rising-edge (EDGE=1) or level (EDGE=0). The block presents one
// unmasked pending line at a time to the CPU and clears it on acknowledge.
//
// Ports:
//   clk        in   single clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   irq_in     in   [N]   raw interrupt lines (synchronous to clk)
//   mask       in   [N]   1 = line excluded from selection (pending kept)
//   ack        in   CPU acknowledge of the presented interrupt
//   irq_req    out  registered request to the CPU
//   irq_id     out  [$clog2(N)] registered index of the presented line
//   irq_onehot out  [N]   registered one-hot form of irq_id
//   pending    out  [N]   pending register
//
// Configuration:
//   IRQ_ROUND_ROBIN_EN defined   -> rotating priority; highest priority goes
//                                   to (last serviced + 1) mod N
//   IRQ_ROUND_ROBIN_EN undefined -> fixed priority, lowest index wins
//
// N must be a power of two and at least 2.

module irq_prio_ctrl #(
  parameter int unsigned N    = 32,
  parameter int unsigned EDGE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         irq_in,
  input  logic [N-1:0]         mask,
  input  logic                 ack,
  output logic                 irq_req,
  output logic [$clog2(N)-1:0] irq_id,
  output logic [N-1:0]         irq_onehot,
  output logic [N-1:0]         pending
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    irq_in_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    onehot_q, onehot_d;
  logic [IW-1:0]   id_q, id_d;
  logic            irq_req_q, irq_req_d;

  logic [N-1:0]    set_vec;
  logic [N-1:0]    clr_vec;
  logic [N-1:0]    eligible;
  logic [N-1:0]    win_onehot;
  logic [IW-1:0]   win_id;

  // Lowest set bit of v. The prefix OR is built in log2(N) doubling steps;
  // shifting it up one gives "some lower bit is set", which masks off
  // every bit above the lowest.
  function automatic logic [N-1:0] lowest_set(input logic [N-1:0] v);
    logic [N-1:0] p;
    p = v;
    for (int unsigned k = 1; k < N; k = k << 1) begin
      p = p | (p << k);
    end
    return v & ~(p << 1);
  endfunction

  // Index of a one-hot (or zero) vector.
  function automatic logic [IW-1:0] oh_to_idx(input logic [N-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (oh[i]) begin
        idx = idx | IW'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    if (EDGE != 0) begin
      set_vec = irq_in & ~irq_in_q;
    end else begin
      set_vec = irq_in;
    end
    eligible = pending_q & ~mask;
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] rr_base;
  logic [N-1:0]  rot_elig;

  // Rotate eligible so that index rr_base lands on bit 0, pick the lowest
  // bit there, then add rr_base back; IW-bit arithmetic wraps modulo N.
  always_comb begin
    rr_base = last_q + IW'(1);
    for (int unsigned i = 0; i < N; i++) begin
      rot_elig[i] = eligible[IW'(i) + rr_base];
    end
    win_id     = oh_to_idx(lowest_set(rot_elig)) + rr_base;
    win_onehot = '0;
    win_onehot[win_id] = 1'b1;
  end
`else
  always_comb begin
    win_onehot = lowest_set(eligible);
    win_id     = oh_to_idx(win_onehot);
  end
`endif

  always_comb begin
    state_d   = state_q;
    irq_req_d = irq_req_q;
    id_d      = id_q;
    onehot_d  = onehot_q;
    clr_vec   = '0;
`ifdef IRQ_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d   = REQ;
          irq_req_d = 1'b1;
          id_d      = win_id;
          onehot_d  = win_onehot;
        end
      end
      REQ: begin
        if (ack) begin
          state_d   = DONE;
          irq_req_d = 1'b0;
          clr_vec   = onehot_q;
`ifdef IRQ_ROUND_ROBIN_EN
          last_d    = id_q;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        irq_req_d = 1'b0;
      end
    endcase
    // A new capture in the ack cycle survives the clear.
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_in_q  <= '0;
      pending_q <= '0;
      onehot_q  <= '0;
      id_q      <= '0;
      irq_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_in_q  <= irq_in;
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      id_q      <= id_d;
      irq_req_q <= irq_req_d;
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign irq_req    = irq_req_q;
  assign irq_id     = id_q;
  assign irq_onehot = onehot_q;
  assign pending    = pending_q;

endmodule

// File: doc/irq_prio_ctrl.md
IRQ_PRIO_CTRL -- requirements
Module: irq_prio_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 32, setting the interrupt line count; N SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter EDGE, default 1, where 1 selects rising-edge capture and 0 selects level capture.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 irq_in  input  N  raw interrupt lines, already synchronous to clk.
REQ-006 mask  input  N  per-line mask; 1 = line disabled for selection.
REQ-007 ack  input  1  CPU acknowledge of the currently presented interrupt.
REQ-008 irq_req  output  1  registered request to the CPU.
REQ-009 irq_id  output  $clog2(N)  registered index of the presented line.
REQ-010 irq_onehot  output  N  registered one-hot form of irq_id.
REQ-011 pending  output  N  pending register, visible to software.

Function
REQ-012 With EDGE=1, pending[i] SHALL set on a cycle where irq_in[i]=1 and the previous-cycle sample of irq_in[i]=0.
REQ-013 With EDGE=0, pending[i] SHALL set on every cycle where irq_in[i]=1.
REQ-014 The eligible vector SHALL be pending & ~mask; masking SHALL NOT clear pending.
REQ-015 The winner SHALL be the lowest-index eligible bit, computed with a log2(N)-level parallel-prefix OR (not a linear chain) as eligible & ~(prefix-OR shifted up one).
REQ-016 The FSM SHALL have three states, IDLE, REQ and DONE, with the following transitions.
REQ-017 IDLE->REQ when eligible is non-zero; in the same edge, the winner SHALL be latched into irq_onehot/irq_id and irq_req SHALL be set, giving 1 cycle latency from pending to irq_req.
REQ-018 In REQ, irq_req, irq_id and irq_onehot SHALL hold stable until ack=1, even if the line is masked or pending changes.
REQ-019 REQ->DONE on ack=1: pending[irq_id] SHALL clear and irq_req SHALL drop on that edge.
REQ-020 DONE->IDLE SHALL occur unconditionally, so irq_req is low for at least one cycle between consecutive requests.
REQ-021 ack in IDLE or DONE SHALL be ignored.
REQ-022 When a set and the ack-clear of the same pending bit occur in the same cycle, the set SHALL win and the bit SHALL remain 1.
REQ-023 When eligible is all-zero, IDLE SHALL be held and irq_onehot/irq_id SHALL keep their last values.

Reset
REQ-024 While rst_n=0, the block SHALL assert asynchronously: state=IDLE, pending=0, the edge-sample register=0, irq_req=0, irq_id=0 and irq_onehot=0.
REQ-025 Reset in REQ SHALL drop irq_req immediately and discard the in-flight interrupt, with no clear-on-ack performed.
REQ-026 After rst_n deasserts, a line already high on the first clock SHALL count as a rising edge when EDGE=1.

Configuration
REQ-027 Macro IRQ_ROUND_ROBIN_EN defined: priority SHALL rotate, giving the highest priority to index (last serviced + 1) mod N with wrap-around. The last-serviced pointer SHALL update on the REQ->DONE transition and SHALL reset to N-1.
REQ-028 Macro IRQ_ROUND_ROBIN_EN undefined: fixed lowest-index priority per REQ-015, and no pointer register SHALL be present.

Verification (N=8, EDGE=1 unless stated)
REQ-029 irq_in=8'h24 pulsed, mask=0 -> next edge pending=8'h24, following edge irq_req=1 and irq_id=2; ack -> pending=8'h20, DONE, then irq_id=5.
REQ-030 pending=8'h01, mask=8'h01 -> irq_req stays 0; mask cleared -> irq_req=1 and irq_id=0 one cycle later.
REQ-031 irq_in[3] re-pulsed in the same cycle as the ack of id 3 -> pending[3] stays 1 and irq_id=3 is re-presented after DONE.
REQ-032 rst_n pulled low mid-REQ with id=4 -> irq_req=0 and pending=0 asynchronously; no ack effect.
REQ-033 EDGE=0, irq_in[7] held high, ack given -> pending[7] re-sets, and the request recurs every 3 cycles.
REQ-034 IRQ_ROUND_ROBIN_EN defined, pending=8'h81 constant -> served ids 0,7,0,7; undefined -> 0,0,0.
